// File: rtl/types.sv
// types: shared brightness mask/plane types, FSM states and counter sizing for the BCM mask generator.
package types;
    typedef logic [7:0] brightness_level_t;
    localparam int W = $bits(brightness_level_t);
    typedef logic [$clog2(W)-1:0] brightness_plane_t;
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} bcm_state_t;
    // Wide enough for the longest lit window and the blank reload, never below 1 bit.
    function automatic int cnt_width(input int base, input int blank);
        int a;
        int b;
        int m;
        a = $clog2(base << (W - 1));
        b = $clog2(blank);
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : m;
    endfunction
endpackage

// File: rtl/brightness_mask_gen.sv
// brightness_mask_gen: rolling one-hot BCM plane mask with a weighted enable window, blank gap and done pulse.
module brightness_mask_gen
    import types::*;
#(
    parameter int BASE_TICKS  = 2,
    parameter int BLANK_TICKS = 1
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              start,
    output brightness_level_t mask,
    output brightness_plane_t plane_index,
    output logic              enable,
    output logic              busy,
    output logic              done
);
    localparam int CW = cnt_width(BASE_TICKS, BLANK_TICKS);
    bcm_state_t        r_state;
    bcm_state_t        w_next;
    logic [CW-1:0]     r_cnt;
    brightness_level_t r_mask;
    brightness_plane_t r_plane;
    logic              r_done;
    logic              w_zero;
    logic              w_finish;
    assign w_zero   = r_cnt == '0;
    assign w_finish = w_zero && ((r_state == BLANK) || (r_state == SHOW && BLANK_TICKS == 0));
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mask  <= {1'b1, {(W-1){1'b0}}};
            r_plane <= brightness_plane_t'(W - 1);
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_finish;
            if (r_state == IDLE && start)
                r_cnt <= CW'((BASE_TICKS << r_plane) - 1);
            else if (r_state == SHOW && w_zero)
                r_cnt <= (BLANK_TICKS > 0) ? CW'(BLANK_TICKS - 1) : '0;
            else if (!w_zero)
                r_cnt <= r_cnt - CW'(1);
            if (w_finish) begin
                r_mask  <= {r_mask[0], r_mask[W-1:1]};
                r_plane <= (r_plane == '0) ? brightness_plane_t'(W - 1) : r_plane - 1'b1;
            end
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? SHOW : IDLE;
            SHOW:    w_next = w_zero ? ((BLANK_TICKS > 0) ? BLANK : IDLE) : SHOW;
            BLANK:   w_next = w_zero ? IDLE : BLANK;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        mask        = r_mask;
        plane_index = r_plane;
        enable      = r_state == SHOW;
        busy        = r_state != IDLE;
        done        = r_done;
    end
endmodule

// File: tb/tb_brightness_mask_gen.sv
// tb_brightness_mask_gen: directed checks of the BCM mask generator in two parameterisations.
module tb_brightness_mask_gen;
    import types::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    brightness_level_t mask_a, mask_b;
    brightness_plane_t plane_a, plane_b;
    logic en_a, en_b, busy_a, busy_b, done_a, done_b;
    int checks = 0;
    int failures = 0;
    int lit, gap, total;

    always #5 clk = ~clk;

    brightness_mask_gen #(.BASE_TICKS(2), .BLANK_TICKS(1)) dut_a (
        .clk_in(clk), .reset_n(rst_n), .start(start_a), .mask(mask_a),
        .plane_index(plane_a), .enable(en_a), .busy(busy_a), .done(done_a)
    );
    brightness_mask_gen #(.BASE_TICKS(1), .BLANK_TICKS(0)) dut_b (
        .clk_in(clk), .reset_n(rst_n), .start(start_b), .mask(mask_b),
        .plane_index(plane_b), .enable(en_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int sel);
        if (sel != 0) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Walks one slot until done, counting lit and unlit busy cycles; optionally pokes start mid-slot.
    task automatic watch(input int sel, input int inj1, input int inj2, output int o_lit, output int o_gap);
        logic [7:0] m0;
        int n;
        int bad;
        m0 = (sel != 0) ? mask_b : mask_a;
        o_lit = 0;
        o_gap = 0;
        n = 0;
        bad = 0;
        while (!((sel != 0) ? done_b : done_a) && n < 5000) begin
            if ((sel != 0) ? en_b : en_a) o_lit++;
            else o_gap++;
            if (((sel != 0) ? mask_b : mask_a) !== m0) bad++;
            if (!((sel != 0) ? busy_b : busy_a)) bad++;
            start_a = (sel == 0) && (n == inj1 || n == inj2);
            n++;
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
        chk("slot_finished_in_budget", 32'(n < 5000), 32'd1);
        chk("mask_stable_and_busy_while_slot", 32'(bad), 32'd0);
        chk("busy_low_in_done_cycle", 32'((sel != 0) ? busy_b : busy_a), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mask", 32'(mask_a), 32'h80);
        chk("reset_plane", 32'(plane_a), 32'd7);
        chk("reset_enable", 32'(en_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_done", 32'(done_a), 32'd0);

        issue(0);
        watch(0, -1, -1, lit, gap);
        chk("p7_lit", 32'(lit), 32'd256);
        chk("p7_gap", 32'(gap), 32'd1);
        chk("p7_mask_after", 32'(mask_a), 32'h40);
        chk("p7_plane_after", 32'(plane_a), 32'd6);
        @(posedge clk);
        #1;
        chk("p7_done_single", 32'(done_a), 32'd0);

        issue(0);
        watch(0, 5, 100, lit, gap);
        chk("p6_ignored_start_lit", 32'(lit), 32'd128);
        chk("p6_ignored_start_gap", 32'(gap), 32'd1);
        chk("p6_mask_after", 32'(mask_a), 32'h20);
        @(posedge clk);
        #1;
        chk("p6_one_done", 32'(done_a), 32'd0);
        chk("p6_no_queued_slot", 32'(busy_a), 32'd0);

        for (int k = 5; k >= 0; k--) begin
            issue(0);
            watch(0, -1, -1, lit, gap);
        end
        chk("wrap_back_mask", 32'(mask_a), 32'h80);

        total = 0;
        for (int k = 0; k < 8; k++) begin
            issue(0);
            watch(0, -1, -1, lit, gap);
            chk("b2b_lit", 32'(lit), 32'(256 >> k));
            chk("b2b_gap", 32'(gap), 32'd1);
            total += lit;
        end
        chk("b2b_total", 32'(total), 32'd510);
        chk("b2b_mask_home", 32'(mask_a), 32'h80);

        for (int k = 0; k < 3; k++) begin
            issue(0);
            watch(0, -1, -1, lit, gap);
        end
        chk("pre_reset_plane", 32'(plane_a), 32'd4);
        @(posedge clk);
        #1;
        issue(0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_show_enable", 32'(en_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_enable_drop", 32'(en_a), 32'd0);
        chk("async_busy_drop", 32'(busy_a), 32'd0);
        chk("async_mask_home", 32'(mask_a), 32'h80);
        chk("async_plane_home", 32'(plane_a), 32'd7);
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_reset", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        total = 0;
        for (int k = 0; k < 7; k++) begin
            issue(1);
            watch(1, -1, -1, lit, gap);
            chk("b_gap_zero", 32'(gap), 32'd0);
            total += lit;
        end
        chk("b_total_p7_to_p1", 32'(total), 32'd254);
        chk("b_mask_p0", 32'(mask_b), 32'h01);
        issue(1);
        chk("b_p0_enable", 32'(en_b), 32'd1);
        @(posedge clk);
        #1;
        chk("b_p0_done", 32'(done_b), 32'd1);
        chk("b_p0_enable_off", 32'(en_b), 32'd0);
        chk("b_mask_wrap", 32'(mask_b), 32'h80);
        chk("b_plane_wrap", 32'(plane_b), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
